data_ram_bus: RTL and testbench

Parametrised, handshaked data memory for the YADAN load/store path. Accepts one load or store request per cycle over a valid/ready request channel and returns a registered response (load data with sign/zero extension, or store completion) over a valid/ready response channel with back-pressure. Detects misaligned and out-of-range accesses and reports them as error responses instead of corrupting memory. Sits between the MEM stage / bus interconnect and the on-chip data array.

---
 rtl/data_ram_bus_if.sv | 29 ++
 rtl/data_ram_bus.sv | 121 ++++++++++++
 tb/tb_data_ram_bus.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_bus_if.sv
// Request/response channel of the data RAM: valid/ready request carrying a load or store,
// valid/ready response carrying extended load data or store completion.
interface data_ram_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_is_store;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_store
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_store
  );
endinterface

// File: rtl/data_ram_bus.sv
// Handshaked byte-addressable data memory for the load/store path: byte-lane stores,
// sign/zero-extended loads, alignment/range checking, single registered response stage.
module data_ram_bus #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4096
) (
  input logic           clk,
  input logic           rst,
  data_ram_bus_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH) * (ADDR_W+1)'(BYTES);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_p1;
  logic [DATA_W-1:0] rsp_rdata_p1;
  logic              rsp_err_p1;
  logic              rsp_is_store_p1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic              misaligned;
  logic              illegal;
  logic              out_of_range;
  logic              err;
  logic              accept;
  logic [DATA_W-1:0] word_rd;
  logic [DATA_W-1:0] wdata_sh;
  logic [BYTES-1:0]  lane_en;

  function automatic logic [BYTES-1:0] lane_mask(input logic [OFF_W-1:0] off_in,
                                                 input logic [1:0] size_in);
    logic [BYTES-1:0] m;
    int lo;
    int n;
    lo = int'(off_in);
    n  = 1 << size_in;
    m  = '0;
    for (int i = 0; i < BYTES; i++) m[i] = (i >= lo) && (i < lo + n);
    return m;
  endfunction

  // Lane is already shifted down to bit 0; widen it with the requested extension.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                    input logic [1:0] size_in,
                                                    input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [DATA_W-1:0]  r;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    r = raw;
    case (size_in)
      2'd0: if (uns) r = DATA_W'(raw[7:0]);  else r = DATA_W'(b);
      2'd1: if (uns) r = DATA_W'(raw[15:0]); else r = DATA_W'(h);
      2'd2: if (uns) r = DATA_W'(raw[31:0]); else r = DATA_W'(w);
      default: r = raw;
    endcase
    return r;
  endfunction

  always_comb begin
    idx          = bus.req_addr[IDX_W+OFF_W-1:OFF_W];
    off          = bus.req_addr[OFF_W-1:0];
    misaligned   = 1'b0;
    case (bus.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
    illegal      = (bus.req_size == 2'd3) && (DATA_W == 32);
    out_of_range = {1'b0, bus.req_addr} >= LIMIT;
    err          = misaligned || illegal || out_of_range;
    word_rd      = mem[idx];
    wdata_sh     = bus.req_wdata << {off, 3'b000};
    lane_en      = lane_mask(off, bus.req_size);
  end

  assign bus.req_ready    = (state_p1 == EMPTY) || bus.rsp_ready;
  assign accept           = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid    = (state_p1 == FULL);
  assign bus.rsp_rdata    = rsp_rdata_p1;
  assign bus.rsp_err      = rsp_err_p1;
  assign bus.rsp_is_store = rsp_is_store_p1;

  // Stage p0 -> array: byte-lane write on the accepting edge, erroneous stores dropped.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // Stage p0 -> p1: response register; a new accept may overwrite a response consumed this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1        <= EMPTY;
      rsp_rdata_p1    <= '0;
      rsp_err_p1      <= 1'b0;
      rsp_is_store_p1 <= 1'b0;
    end else if (accept) begin
      state_p1        <= FULL;
      rsp_err_p1      <= err;
      rsp_is_store_p1 <= bus.req_we;
      if (bus.req_we || err) rsp_rdata_p1 <= '0;
      else rsp_rdata_p1 <= extend_load(word_rd >> {off, 3'b000}, bus.req_size, bus.req_unsigned);
    end else if ((state_p1 == FULL) && bus.rsp_ready) begin
      state_p1        <= EMPTY;
    end
  end
endmodule

// File: tb/tb_data_ram_bus.sv
// Bench for data_ram_bus: directed and randomized traffic scored against a byte-array
// reference model, plus a short directed run on a 64-bit instance.
module tb_data_ram_bus;
  localparam int DEPTH = 64;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_bus_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  data_ram_bus_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  data_ram_bus #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  data_ram_bus #(.DATA_W(64), .ADDR_W(32), .DEPTH(32))    dut64 (.clk(clk), .rst(rst), .bus(bus64));

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        st;
  } rsp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  rsp_t        q[$];
  logic [7:0]  mem_m [NB];
  int          hold = 0;
  bit          rand_ready = 0;
  bit          stall_prev = 0;
  logic [31:0] sv_rdata;
  logic        sv_err, sv_st;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, loads assembled little-endian then extended.
  function automatic rsp_t model_apply(input logic we, input logic [31:0] addr,
                                       input logic [1:0] size, input logic uns,
                                       input logic [31:0] wdata);
    rsp_t r;
    int nb;
    logic [63:0] v;
    nb      = 1 << size;
    r.st    = we;
    r.rdata = '0;
    r.err   = (size == 2'd3) || ((addr % nb) != 0) || (addr >= NB);
    if (!r.err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mem_m[int'(addr) + k] = wdata[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (64'(mem_m[int'(addr) + k]) << (8*k));
        if (!uns && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
        r.rdata = v[31:0];
      end
    end
    return r;
  endfunction

  task automatic step(output bit acc);
    rsp_t e;
    @(negedge clk);
    acc = 0;
    check("req_ready_rule", bus.req_ready, !bus.rsp_valid || bus.rsp_ready);
    if (stall_prev) begin
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_rdata", bus.rsp_rdata, sv_rdata);
      check("hold_err", bus.rsp_err, sv_err);
      check("hold_is_store", bus.rsp_is_store, sv_st);
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) check("rsp_unexpected", bus.rsp_valid, 1'b0);
      else begin
        e = q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", bus.rsp_err, e.err);
        check("rsp_is_store", bus.rsp_is_store, e.st);
      end
      last_rdata = bus.rsp_rdata;
      last_err   = bus.rsp_err;
    end
    stall_prev = bus.rsp_valid && !bus.rsp_ready;
    sv_rdata = bus.rsp_rdata;
    sv_err   = bus.rsp_err;
    sv_st    = bus.rsp_is_store;
    if (bus.req_valid && bus.req_ready) begin
      q.push_back(model_apply(bus.req_we, bus.req_addr, bus.req_size, bus.req_unsigned, bus.req_wdata));
      acc = 1;
    end
    @(posedge clk);
    #1;
    if (hold > 0) begin
      bus.rsp_ready = 1'b0;
      hold--;
    end else begin
      bus.rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
    bit acc;
    acc = 0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    for (int i = 0; i < 40; i++) begin
      step(acc);
      if (acc) break;
    end
    check("req_accept", acc, 1'b1);
  endtask

  task automatic drain();
    bit acc;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      step(acc);
    end
    check("drain_left", q.size(), 0);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input string tag,
                      input logic [31:0] exp_rdata, input logic exp_err);
    run_req(we, addr, size, uns, wdata);
    drain();
    check({tag, "_rdata"}, last_rdata, exp_rdata);
    check({tag, "_err"}, last_err, exp_err);
  endtask

  task automatic x64(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [63:0] wdata,
                     output logic [63:0] rdata, output logic err);
    bit acc, got;
    acc = 0;
    got = 0;
    bus64.req_valid    = 1'b1;
    bus64.req_we       = we;
    bus64.req_addr     = addr;
    bus64.req_size     = size;
    bus64.req_unsigned = uns;
    bus64.req_wdata    = wdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = bus64.req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    bus64.req_valid = 1'b0;
    rdata = '0;
    err   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus64.rsp_valid) begin
        rdata = bus64.rsp_rdata;
        err   = bus64.rsp_err;
        got   = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("x64_handshake", {acc, got}, 2'b11);
  endtask

  initial begin
    logic [63:0] r64;
    logic        e64;
    logic [31:0] a;
    logic [1:0]  sz;

    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_unsigned = 0; bus.req_wdata = '0; bus.rsp_ready = 1;
    bus64.req_valid = 0; bus64.req_we = 0; bus64.req_addr = '0; bus64.req_size = '0;
    bus64.req_unsigned = 0; bus64.req_wdata = '0; bus64.rsp_ready = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", bus.rsp_err, 1'b0);
    check("reset_rsp_is_store", bus.rsp_is_store, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_req_ready", bus.req_ready, 1'b1);

    // Byte lanes
    xact(1, 32'h10, 2, 0, 32'h11223344, "st_word", 32'h0, 0);
    xact(1, 32'h12, 0, 0, 32'hFFFFFFAA, "st_byte", 32'h0, 0);
    xact(1, 32'h10, 1, 0, 32'h1234BEEF, "st_half", 32'h0, 0);
    xact(0, 32'h10, 2, 0, 32'h0, "ld_lanes", 32'h11AABEEF, 0);
    // Extension
    xact(1, 32'h20, 2, 0, 32'h800080F0, "st_ext", 32'h0, 0);
    xact(0, 32'h20, 0, 0, 32'h0, "ld_b_s", 32'hFFFFFFF0, 0);
    xact(0, 32'h20, 0, 1, 32'h0, "ld_b_u", 32'h000000F0, 0);
    xact(0, 32'h22, 1, 0, 32'h0, "ld_h_s", 32'hFFFF8000, 0);
    xact(0, 32'h22, 1, 1, 32'h0, "ld_h_u", 32'h00008000, 0);
    // Errors leave memory intact
    xact(1, 32'h21, 1, 0, 32'hDEADBEEF, "err_st_h", 32'h0, 1);
    xact(1, 32'h22, 2, 0, 32'hDEADBEEF, "err_st_w", 32'h0, 1);
    xact(0, 32'h20, 3, 0, 32'h0, "err_ld_d", 32'h0, 1);
    xact(0, NB, 2, 0, 32'h0, "err_ld_oor", 32'h0, 1);
    xact(1, NB + 32'h20, 2, 0, 32'hDEADBEEF, "err_st_oor", 32'h0, 1);
    xact(0, 32'h20, 2, 0, 32'h0, "ld_unchanged", 32'h800080F0, 0);

    // Back-pressure: 4 back-to-back loads, response stalled 3 cycles after the first
    bus.rsp_ready = 1'b0;
    hold = 3;
    run_req(0, 32'h10, 2, 0, 32'h0);
    run_req(0, 32'h20, 2, 0, 32'h0);
    run_req(0, 32'h12, 1, 0, 32'h0);
    run_req(0, 32'h23, 0, 0, 32'h0);
    drain();
    check("bp_last", last_rdata, 32'hFFFFFF80);

    // Reset while a response is pending
    bus.rsp_ready = 1'b0;
    hold = 1000;
    run_req(0, 32'h10, 2, 0, 32'h0);
    bus.req_valid = 1'b0;
    check("rst_pre_valid", bus.rsp_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", bus.rsp_valid, 1'b0);
    check("rst_mid_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mid_err", bus.rsp_err, 1'b0);
    check("rst_mid_is_store", bus.rsp_is_store, 1'b0);
    q.delete();
    stall_prev = 0;
    hold = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("rst_post_req_ready", bus.req_ready, 1'b1);
    check("rst_post_valid", bus.rsp_valid, 1'b0);

    // Fill every word so all later loads are predictable
    for (int w = 0; w < DEPTH; w++) run_req(1, 32'(w * 4), 2, 0, $urandom);
    drain();

    // Randomized traffic with random response back-pressure
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      bit acc;
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, NB - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 4) == 0) begin
        bus.req_valid = 1'b0;
        step(acc);
      end
    end
    rand_ready = 0;
    drain();

    // 64-bit instance
    x64(1, 32'h8, 3, 0, 64'h0123456789ABCDEF, r64, e64);
    check("d64_st_err", e64, 1'b0);
    check("d64_st_rdata", r64, 64'h0);
    x64(0, 32'hC, 2, 0, 64'h0, r64, e64);
    check("d64_ld_w_hi", r64, 64'h0000000001234567);
    x64(0, 32'h8, 2, 0, 64'h0, r64, e64);
    check("d64_ld_w_lo_s", r64, 64'hFFFFFFFF89ABCDEF);
    x64(0, 32'h8, 2, 1, 64'h0, r64, e64);
    check("d64_ld_w_lo_u", r64, 64'h0000000089ABCDEF);
    x64(0, 32'h8, 3, 0, 64'h0, r64, e64);
    check("d64_ld_d", r64, 64'h0123456789ABCDEF);
    check("d64_ld_d_err", e64, 1'b0);
    x64(0, 32'h9, 0, 0, 64'h0, r64, e64);
    check("d64_ld_b_s", r64, 64'hFFFFFFFFFFFFFFCD);
    x64(0, 32'hC, 3, 0, 64'h0, r64, e64);
    check("d64_ld_d_mis_err", e64, 1'b1);
    check("d64_ld_d_mis_rdata", r64, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
